// File: rtl/adder_lbist_top.sv
// Purpose: N-bit ripple adder with registered functional path and on-chip logic BIST (LFSR -> adder -> MISR).
// Latency: functional 2 cycles pin-to-pin; BIST done PATTERNS+3 cycles after the start cycle.
// Backpressure: none; free-running datapath, pin_start is ignored while busy or in functional mode.
//
// Ports:
//   pin_clk, pin_rst            clock (rising edge), synchronous active-high reset
//   pin_a, pin_b, pin_cin       functional operands (sampled when pin_sel=0)
//   pin_sel                     0 functional, 1 test; dropping it mid-run aborts the BIST
//   pin_start                   BIST start pulse (IDLE or DONE, test mode only)
//   pin_sum, pin_co             functional result (sel=0) or live MISR contents (sel=1)
//   pin_busy, pin_done, pin_pass BIST status; pass is meaningful only while done
module adder_lbist_top #(
    parameter int             N         = 16,
    parameter int             PATTERNS  = 256,
    parameter logic [2*N:0]   SEED      = 33'h1,
    parameter logic [2*N:0]   LFSR_TAPS = 33'h1_0008_0000,
    parameter logic [N:0]     MISR_TAPS = 17'h1_2000,
    parameter logic [N:0]     GOLDEN    = 17'h0
) (
    input  logic         pin_clk,
    input  logic         pin_rst,
    input  logic [N-1:0] pin_a,
    input  logic [N-1:0] pin_b,
    input  logic         pin_cin,
    input  logic         pin_sel,
    input  logic         pin_start,
    output logic [N-1:0] pin_sum,
    output logic         pin_co,
    output logic         pin_busy,
    output logic         pin_done,
    output logic         pin_pass
);

    localparam int              W    = 2 * N + 1;
    localparam int              CW   = $clog2(PATTERNS + 1);
    localparam logic [CW-1:0]   LAST = CW'(PATTERNS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [W-1:0]    lfsr;
    logic [W-1:0]    lfsr_next;
    logic [N:0]      misr;
    logic [N:0]      misr_next;
    logic [CW-1:0]   count;
    logic            drain_cnt;

    // Stage 1: operand register {cin, b, a}; stage 2: result register {co, sum}
    logic [W-1:0]    in_reg;
    logic            in_vld;
    logic [N:0]      res_reg;
    logic            res_vld;
    logic [N:0]      add_res;

    logic            start_run;
    logic            issue;

    // Ripple-carry adder on the operand register
    always_comb begin
        logic [N:0] carry;
        carry    = '0;
        add_res  = '0;
        carry[0] = in_reg[W-1];
        for (int i = 0; i < N; i++) begin
            add_res[i]   = in_reg[i] ^ in_reg[N+i] ^ carry[i];
            carry[i+1]   = (in_reg[i] & in_reg[N+i]) | (carry[i] & (in_reg[i] ^ in_reg[N+i]));
        end
        add_res[N] = carry[N];
    end

    // Galois LFSR and MISR next-state
    always_comb begin
        lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
        misr_next = (misr >> 1) ^ (misr[0] ? MISR_TAPS : '0) ^ res_reg;
    end

    // Next-state / control decode
    always_comb begin
        state_n   = state;
        start_run = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (pin_start) begin
                    start_run = 1'b1;
                    state_n   = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (count == LAST) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                // drain_cnt marks the second drain cycle
                if (drain_cnt) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (pin_start) begin
                    start_run = 1'b1;
                    state_n   = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
        // Functional mode overrides everything: hold or abort to IDLE
        if (!pin_sel) begin
            state_n   = IDLE;
            start_run = 1'b0;
            issue     = 1'b0;
        end
    end

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            state     <= IDLE;
            lfsr      <= SEED;
            misr      <= '0;
            count     <= '0;
            drain_cnt <= 1'b0;
            in_reg    <= '0;
            in_vld    <= 1'b0;
            res_reg   <= '0;
            res_vld   <= 1'b0;
        end else begin
            state     <= state_n;
            drain_cnt <= (state == DRAIN) && pin_sel && !drain_cnt;

            if (start_run) begin
                lfsr  <= SEED;
                count <= '0;
            end else if (issue) begin
                lfsr  <= lfsr_next;
                count <= count + 1'b1;
            end

            if (!pin_sel) begin
                in_reg <= {pin_cin, pin_b, pin_a};
            end else if (issue) begin
                in_reg <= lfsr;
            end
            in_vld  <= issue;

            res_reg <= add_res;
            // An abort kills any result still in flight
            res_vld <= in_vld && pin_sel;

            // MISR is left untouched on abort so the partial signature stays visible
            if (start_run) begin
                misr <= '0;
            end else if (res_vld && pin_sel) begin
                misr <= misr_next;
            end
        end
    end

    always_comb begin
        pin_sum  = pin_sel ? misr[N-1:0] : res_reg[N-1:0];
        pin_co   = pin_sel ? misr[N]     : res_reg[N];
        pin_busy = (state == RUN) || (state == DRAIN);
        pin_done = (state == DONE);
        pin_pass = (state == DONE) && (misr == GOLDEN);
    end

endmodule

// File: tb/tb_adder_lbist_top.sv
module tb_adder_lbist_top;

    localparam int          N         = 16;
    localparam int          P         = 256;
    localparam logic [32:0] SEED      = 33'h1;
    localparam logic [32:0] LFSR_TAPS = 33'h1_0008_0000;
    localparam logic [16:0] MISR_TAPS = 17'h1_2000;

    // Reference signature: straight arithmetic over the pattern sequence
    function automatic logic [16:0] model_sig(input int n);
        logic [32:0] l;
        logic [16:0] m;
        logic [16:0] r;
        l = SEED;
        m = '0;
        for (int i = 0; i < n; i++) begin
            r = {1'b0, l[15:0]} + {1'b0, l[31:16]} + {16'b0, l[32]};
            m = (m >> 1) ^ (m[0] ? MISR_TAPS : 17'h0) ^ r;
            l = (l >> 1) ^ (l[0] ? LFSR_TAPS : 33'h0);
        end
        return m;
    endfunction

    localparam logic [16:0] GOLD = model_sig(P);

    logic          pin_clk = 1'b0;
    logic          pin_rst;
    logic [N-1:0]  pin_a;
    logic [N-1:0]  pin_b;
    logic          pin_cin;
    logic          pin_sel;
    logic          pin_start;

    logic [N-1:0]  sum_f, sum_b, sum_m;
    logic          co_f, co_b, co_m;
    logic          busy_f, busy_b, busy_m;
    logic          done_f, done_b, done_m;
    logic          pass_f, pass_b, pass_m;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_sig;

    always #5 pin_clk = ~pin_clk;

    adder_lbist_top #(.GOLDEN(GOLD)) dut_full (
        .pin_clk(pin_clk), .pin_rst(pin_rst), .pin_a(pin_a), .pin_b(pin_b),
        .pin_cin(pin_cin), .pin_sel(pin_sel), .pin_start(pin_start),
        .pin_sum(sum_f), .pin_co(co_f), .pin_busy(busy_f), .pin_done(done_f), .pin_pass(pass_f)
    );

    adder_lbist_top #(.GOLDEN(GOLD ^ 17'h1)) dut_bad (
        .pin_clk(pin_clk), .pin_rst(pin_rst), .pin_a(pin_a), .pin_b(pin_b),
        .pin_cin(pin_cin), .pin_sel(pin_sel), .pin_start(pin_start),
        .pin_sum(sum_b), .pin_co(co_b), .pin_busy(busy_b), .pin_done(done_b), .pin_pass(pass_b)
    );

    adder_lbist_top #(.PATTERNS(1), .GOLDEN(17'h00001)) dut_min (
        .pin_clk(pin_clk), .pin_rst(pin_rst), .pin_a(pin_a), .pin_b(pin_b),
        .pin_cin(pin_cin), .pin_sel(pin_sel), .pin_start(pin_start),
        .pin_sum(sum_m), .pin_co(co_m), .pin_busy(busy_m), .pin_done(done_m), .pin_pass(pass_m)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pin_clk);
        #1;
    endtask

    // Start pulse in the current cycle (cycle 0), then walk cycles 1..P+4 checking status.
    // A spurious start is injected in cycle spur_c to show it is ignored during RUN.
    task automatic bist_run(input int spur_c);
        pin_start = 1'b1;
        tick();
        pin_start = 1'b0;
        for (int c = 1; c <= P + 4; c++) begin
            pin_start = (c == spur_c);
            @(negedge pin_clk);
            check("busy_full", 32'(busy_f), 32'(c <= P + 2));
            check("done_full", 32'(done_f), 32'(c >= P + 3));
            if (c <= 3) check("busy_min", 32'(busy_m), 32'h1);
            if (c == 4) begin
                check("done_min", 32'(done_m), 32'h1);
                check("pass_min", 32'(pass_m), 32'h1);
                check("sig_min",  32'({co_m, sum_m}), 32'h00001);
            end
            if (c == P + 3) begin
                check("pass_full", 32'(pass_f), 32'h1);
                check("sig_full",  32'({co_f, sum_f}), 32'(exp_sig));
                check("done_bad",  32'(done_b), 32'h1);
                check("pass_bad",  32'(pass_b), 32'h0);
            end
            tick();
        end
        pin_start = 1'b0;
    endtask

    initial begin
        exp_sig   = model_sig(P);
        pin_rst   = 1'b1;
        pin_a     = '0;
        pin_b     = '0;
        pin_cin   = 1'b0;
        pin_sel   = 1'b0;
        pin_start = 1'b0;
        tick();
        tick();
        @(negedge pin_clk);
        check("rst_sum",  32'(sum_f),  32'h0);
        check("rst_co",   32'(co_f),   32'h0);
        check("rst_busy", 32'(busy_f), 32'h0);
        check("rst_done", 32'(done_f), 32'h0);
        check("rst_pass", 32'(pass_f), 32'h0);
        tick();
        pin_rst = 1'b0;

        // Functional path, 2-cycle latency
        pin_a = 16'hFFFF; pin_b = 16'h0001; pin_cin = 1'b0;
        tick();
        pin_a = 16'h1234; pin_b = 16'h4321; pin_cin = 1'b1;
        tick();
        pin_a = 16'h0000; pin_b = 16'h0000; pin_cin = 1'b0;
        @(negedge pin_clk);
        check("func1_sum", 32'(sum_f), 32'h0000);
        check("func1_co",  32'(co_f),  32'h1);
        check("func_busy", 32'(busy_f), 32'h0);
        tick();
        @(negedge pin_clk);
        check("func2_sum", 32'(sum_f), 32'h5556);
        check("func2_co",  32'(co_f),  32'h0);
        tick();

        // Start while in functional mode is ignored
        pin_start = 1'b1;
        tick();
        pin_start = 1'b0;
        @(negedge pin_clk);
        check("start_sel0_busy", 32'(busy_f), 32'h0);
        tick();

        // BIST from IDLE, with a spurious start during RUN
        pin_sel = 1'b1;
        tick();
        bist_run(10);

        // Restart from DONE
        bist_run(0);

        // Abort by dropping sel in cycle 50
        pin_start = 1'b1;
        tick();
        pin_start = 1'b0;
        repeat (49) tick();
        pin_sel = 1'b0;
        tick();
        @(negedge pin_clk);
        check("abort_busy", 32'(busy_f), 32'h0);
        check("abort_done", 32'(done_f), 32'h0);
        check("abort_pass", 32'(pass_f), 32'h0);
        tick();
        pin_sel = 1'b1;
        tick();
        @(negedge pin_clk);
        check("idle_after_abort_busy", 32'(busy_f), 32'h0);
        tick();
        bist_run(0);

        // Reset asserted in cycle 100 of a run
        pin_start = 1'b1;
        tick();
        pin_start = 1'b0;
        repeat (99) tick();
        pin_rst = 1'b1;
        tick();
        @(negedge pin_clk);
        check("midrst_sum",  32'(sum_f),  32'h0);
        check("midrst_co",   32'(co_f),   32'h0);
        check("midrst_busy", 32'(busy_f), 32'h0);
        check("midrst_done", 32'(done_f), 32'h0);
        check("midrst_pass", 32'(pass_f), 32'h0);
        pin_rst = 1'b0;
        tick();
        @(negedge pin_clk);
        check("post_rst_idle", 32'(busy_f), 32'h0);
        tick();
        bist_run(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
